grid_access_arbiter: RTL and testbench

- Shares the single-port placement grid RAM among N_REQ placement workers.
- Supported operations: read, write, and atomic claim (test-and-set: write only if the cell holds EMPTY = -1).
- Sits between the workers and the grid RAM. The RAM has a registered read port with read enable, write enable and address.
- Serialises requests with round-robin fairness so that two workers can never claim the same cell.

---
 rtl/grid_arb_pkg.sv | 22 ++
 rtl/grid_access_arbiter_rr_arbiter.sv | 31 +++
 rtl/grid_access_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_grid_access_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_arb_pkg.sv
// Shared definitions for the placement-grid access arbiter: op codes,
// the empty-cell marker and the controller state encoding.
package grid_arb_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLAIM = 2'b10;

  // A grid cell holding this value has no node placed in it.
  localparam logic signed [31:0] CELL_EMPTY = -32'sd1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    CHECK,
    WR,
    ERR,
    RESP
  } arb_state_e;

endpackage

// File: rtl/grid_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first requester at or
// after rr_ptr (wrapping) as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  // Scan requesters starting at the pointer and stop at the first one set.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/grid_access_arbiter.sv
// Serialises read / write / claim requests from the placement workers onto
// the single-port grid RAM. Only one operation is ever in flight, which is
// what makes the claim (test-and-set on an empty cell) atomic.
module grid_access_arbiter
  import grid_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int GRID_CELLS = 64,
  parameter int RD_LAT     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [2*N_REQ-1:0]        req_op,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_ok,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [DATA_W-1:0] EMPTY_VAL = DATA_W'(CELL_EMPTY);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ok_q, ok_d;

  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_ok_q, rsp_ok_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign sel_op    = req_op[int'(grant_idx)*2 +: 2];
  assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];

  assign req_ready = (state_q == IDLE) ? grant : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ok    = rsp_ok_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // State register: all flops, cleared by reset so an in-flight op is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ok_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_ok_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ok_q        <= ok_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ok_q    <= rsp_ok_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic: accept, sequence the RAM access and build the result.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ok_d     = ok_q;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          op_d     = (sel_op == OP_WRITE || sel_op == OP_CLAIM) ? sel_op : OP_READ;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          owner_d  = grant_idx;
          rr_ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
          if (sel_addr >= ADDR_W'(GRID_CELLS)) begin
            state_d = ERR;
          end else if (sel_op == OP_WRITE) begin
            state_d = WR;
            rdata_d = sel_wdata;
            ok_d    = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(RD_LAT);
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = mem_rdata;
          if (op_q == OP_CLAIM) begin
            state_d = CHECK;
          end else begin
            ok_d    = 1'b1;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHECK: begin
        if (rdata_q == EMPTY_VAL) begin
          ok_d    = 1'b1;
          state_d = WR;
        end else begin
          ok_d    = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        state_d = RESP;
      end
      ERR: begin
        rdata_d = EMPTY_VAL;
        ok_d    = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: registered strobes follow the state being entered.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_ok_d    = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_d)
      RD: begin
        mem_read_d = 1'b1;
        mem_addr_d = addr_d;
      end
      WR: begin
        mem_write_d = 1'b1;
        mem_addr_d  = addr_d;
        mem_wdata_d = wdata_d;
      end
      RESP: begin
        rsp_valid_d[owner_d] = 1'b1;
        rsp_data_d           = rdata_d;
        rsp_ok_d             = ok_d;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed bench for grid_access_arbiter with a behavioural grid RAM
// (registered read, one cycle latency).
module tb_grid_access_arbiter;

  localparam int N_REQ      = 4;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int GRID_CELLS = 64;
  localparam int RD_LAT     = 1;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CL  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [DATA_W-1:0] EMPTY = 32'hFFFF_FFFF;

  logic                     clk;
  logic                     reset;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [2*N_REQ-1:0]       req_op;
  logic [N_REQ*ADDR_W-1:0]  req_addr;
  logic [N_REQ*DATA_W-1:0]  req_wdata;
  logic [N_REQ-1:0]         rsp_valid;
  logic [DATA_W-1:0]        rsp_data;
  logic                     rsp_ok;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  logic [DATA_W-1:0] ram [0:GRID_CELLS-1];
  logic ramInit = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  grid_access_arbiter #(
    .N_REQ      (N_REQ),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .GRID_CELLS (GRID_CELLS),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ok    (rsp_ok),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grid RAM model: first edge fills every cell with EMPTY and cell 10 with 5.
  always @(posedge clk) begin
    if (!ramInit) begin
      for (int i = 0; i < GRID_CELLS; i++) ram[i] <= EMPTY;
      ram[10]   <= 32'd5;
      mem_rdata <= '0;
      ramInit   <= 1'b1;
    end else begin
      if (mem_write) ram[mem_addr[5:0]] <= mem_wdata;
      if (mem_read) mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise a request on one worker port.
  task automatic applyStimulus(input int idx, input logic [1:0] op,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    req_op[idx*2 +: 2]             = op;
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    req_wdata[idx*DATA_W +: DATA_W] = wdata;
    req_valid[idx]                 = 1'b1;
  endtask

  // Synchronous reset pulse, called at a falling edge.
  task automatic doReset();
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
  endtask

  // Follow one operation from its accept cycle through its response.
  // expRdCyc / expWrCyc give the cycle offset of the RAM strobe (0 = none).
  task automatic runOp(input string tag, input int idx,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                       input int lat, input logic [DATA_W-1:0] expData, input logic expOk,
                       input int expRdCyc, input int expWrCyc, input logic drop);
    logic [N_REQ-1:0] oneHot;
    int rdCnt, wrCnt, rdCyc, wrCyc;
    logic [ADDR_W-1:0] rdAddr, wrAddr;
    logic [DATA_W-1:0] wrData;
    logic early, both;
    oneHot = '0;
    oneHot[idx] = 1'b1;
    rdCnt = 0; wrCnt = 0; rdCyc = 0; wrCyc = 0;
    rdAddr = '0; wrAddr = '0; wrData = '0;
    early = 1'b0; both = 1'b0;
    #1;
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'(oneHot));
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1 && drop) req_valid[idx] = 1'b0;
      if (mem_read && mem_write) both = 1'b1;
      if (mem_read) begin rdCnt++; rdCyc = c; rdAddr = mem_addr; end
      if (mem_write) begin wrCnt++; wrCyc = c; wrAddr = mem_addr; wrData = mem_wdata; end
      if (c < lat && rsp_valid != '0) early = 1'b1;
      if (c == lat) begin
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oneHot));
        checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'(expData));
        checkOutput({tag, "_rsp_ok"}, 64'(rsp_ok), 64'(expOk));
      end
    end
    checkOutput({tag, "_early_rsp"}, 64'(early), 64'd0);
    checkOutput({tag, "_rd_wr_overlap"}, 64'(both), 64'd0);
    checkOutput({tag, "_rd_count"}, 64'(rdCnt), (expRdCyc != 0) ? 64'd1 : 64'd0);
    checkOutput({tag, "_wr_count"}, 64'(wrCnt), (expWrCyc != 0) ? 64'd1 : 64'd0);
    if (expRdCyc != 0) begin
      checkOutput({tag, "_rd_cycle"}, 64'(rdCyc), 64'(expRdCyc));
      checkOutput({tag, "_rd_addr"}, 64'(rdAddr), 64'(addr));
    end
    if (expWrCyc != 0) begin
      checkOutput({tag, "_wr_cycle"}, 64'(wrCyc), 64'(expWrCyc));
      checkOutput({tag, "_wr_addr"}, 64'(wrAddr), 64'(addr));
      checkOutput({tag, "_wr_data"}, 64'(wrData), 64'(wdata));
    end
    @(negedge clk);
    checkOutput({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  // Directed scenario sequence.
  initial begin
    logic wrSeen, rspSeen;
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_ok", 64'(rsp_ok), 64'd0);
    checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("rst_mem_read", 64'(mem_read), 64'd0);
    checkOutput("rst_mem_write", 64'(mem_write), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single read");
    applyStimulus(0, OP_RD, 12'd10, 32'd0);
    runOp("t1_read", 0, 12'd10, 32'd0, 3, 32'd5, 1'b1, 1, 0, 1'b1);

    $display("[TB] claim won");
    applyStimulus(1, OP_CL, 12'd20, 32'd7);
    runOp("t2_claim", 1, 12'd20, 32'd7, 5, EMPTY, 1'b1, 1, 4, 1'b1);
    checkOutput("t2_cell20", 64'(ram[20]), 64'd7);
    applyStimulus(1, OP_RD, 12'd20, 32'd0);
    runOp("t2_readback", 1, 12'd20, 32'd0, 3, 32'd7, 1'b1, 1, 0, 1'b1);

    $display("[TB] claim race");
    doReset();
    applyStimulus(0, OP_CL, 12'd30, 32'd3);
    applyStimulus(2, OP_CL, 12'd30, 32'd9);
    runOp("t3_win", 0, 12'd30, 32'd3, 5, EMPTY, 1'b1, 1, 4, 1'b1);
    runOp("t3_lose", 2, 12'd30, 32'd9, 4, 32'd3, 1'b0, 1, 0, 1'b1);
    checkOutput("t3_cell30", 64'(ram[30]), 64'd3);

    $display("[TB] round robin");
    doReset();
    applyStimulus(0, OP_RD, 12'd10, 32'd0);
    applyStimulus(1, OP_RD, 12'd20, 32'd0);
    applyStimulus(2, OP_RD, 12'd30, 32'd0);
    applyStimulus(3, OP_RD, 12'd41, 32'd0);
    runOp("t4_rr0", 0, 12'd10, 32'd0, 3, 32'd5, 1'b1, 1, 0, 1'b0);
    runOp("t4_rr1", 1, 12'd20, 32'd0, 3, 32'd7, 1'b1, 1, 0, 1'b0);
    runOp("t4_rr2", 2, 12'd30, 32'd0, 3, 32'd3, 1'b1, 1, 0, 1'b0);
    runOp("t4_rr3", 3, 12'd41, 32'd0, 3, EMPTY, 1'b1, 1, 0, 1'b0);
    runOp("t4_rr4", 0, 12'd10, 32'd0, 3, 32'd5, 1'b1, 1, 0, 1'b0);
    req_valid = '0;

    $display("[TB] range error, write, reserved op");
    applyStimulus(3, OP_RD, 12'd64, 32'd0);
    runOp("t5_range", 3, 12'd64, 32'd0, 2, EMPTY, 1'b0, 0, 0, 1'b1);
    applyStimulus(1, OP_WR, 12'd50, 32'h1234);
    runOp("t5_write", 1, 12'd50, 32'h1234, 2, 32'h1234, 1'b1, 0, 1, 1'b1);
    applyStimulus(2, OP_RSV, 12'd50, 32'hBEEF);
    runOp("t5_rsvd", 2, 12'd50, 32'hBEEF, 3, 32'h1234, 1'b1, 1, 0, 1'b1);
    checkOutput("t5_cell50", 64'(ram[50]), 64'h1234);

    $display("[TB] reset mid-claim");
    doReset();
    applyStimulus(0, OP_CL, 12'd40, 32'hAA);
    #1;
    checkOutput("t6_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    checkOutput("t6_mem_read", 64'(mem_read), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wrSeen  = mem_write;
    rspSeen = |rsp_valid;
    checkOutput("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("t6_rsp_ok", 64'(rsp_ok), 64'd0);
    checkOutput("t6_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("t6_mem_read0", 64'(mem_read), 64'd0);
    checkOutput("t6_mem_write", 64'(mem_write), 64'd0);
    checkOutput("t6_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("t6_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_write) wrSeen = 1'b1;
      if (rsp_valid != '0) rspSeen = 1'b1;
    end
    checkOutput("t6_no_write", 64'(wrSeen), 64'd0);
    checkOutput("t6_no_rsp", 64'(rspSeen), 64'd0);
    checkOutput("t6_cell40", 64'(ram[40]), 64'(EMPTY));
    for (int i = 0; i < N_REQ; i++) applyStimulus(i, OP_RD, 12'd0, 32'd0);
    #1;
    checkOutput("t6_rr_ptr", 64'(req_ready), 64'd1);
    req_valid = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
